// File: rtl/fwd_scoreboard_unit.sv
// Decode-stage operand forwarding, long-latency write scoreboard and hazard detect.
// Define FWD_SCOREBOARD_PERF_EN to build the saturating hazard-stall counter.
module fwd_scoreboard_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int NUM_SRC      = 2,
    parameter int NUM_FWD      = 3,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_SRC-1:0]                  i_src_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]       i_src_addr,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]       i_src_rf_data,
    input  logic [NUM_FWD-1:0]                  i_fwd_valid,
    input  logic [NUM_FWD*REG_ADDR_W-1:0]       i_fwd_addr,
    input  logic [NUM_FWD*DATA_WIDTH-1:0]       i_fwd_data,
    input  logic [NUM_FWD-1:0]                  i_fwd_ready,
    input  logic                                i_issue_valid,
    input  logic [REG_ADDR_W-1:0]               i_issue_addr,
    output logic                                o_issue_ready,
    input  logic                                i_done_valid,
    input  logic [REG_ADDR_W-1:0]               i_done_addr,
    input  logic [DATA_WIDTH-1:0]               i_done_data,
    input  logic                                i_flush,
    output logic [NUM_SRC*DATA_WIDTH-1:0]       o_src_data,
    output logic                                o_hazard,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]   o_pending_count,
    output logic [CNT_W-1:0]                    o_stall_cycles
);

    localparam int PCW = $clog2(MAX_INFLIGHT + 1);

    logic [MAX_INFLIGHT-1:0] sb_valid;
    logic [MAX_INFLIGHT-1:0] sb_valid_n;
    logic [MAX_INFLIGHT-1:0] done_hit;
    logic [MAX_INFLIGHT-1:0] surv;
    logic [MAX_INFLIGHT-1:0] waw_hit;
    logic [MAX_INFLIGHT-1:0] alloc_oh;
    logic [REG_ADDR_W-1:0]   sb_addr [MAX_INFLIGHT];
    logic [NUM_SRC-1:0]      src_hz;
    logic                    do_issue;

    // Entries retired by this cycle's done are already free for a new issue.
    always_comb begin
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            done_hit[i] = sb_valid[i] && i_done_valid
                          && (sb_addr[i] == i_done_addr);
        end
        surv = sb_valid & ~done_hit;
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            waw_hit[i] = surv[i] && (sb_addr[i] == i_issue_addr);
        end
        alloc_oh = ~surv & (surv + MAX_INFLIGHT'(1));
        o_issue_ready = !i_flush
                        && ((i_issue_addr == '0)
                            || (!(&surv) && !(|waw_hit)));
        do_issue = i_issue_valid && o_issue_ready
                   && (i_issue_addr != '0);
        sb_valid_n = surv | (do_issue ? alloc_oh : '0);
    end

    always_comb begin
        o_pending_count = '0;
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            o_pending_count = o_pending_count + PCW'(sb_valid[i]);
        end
    end

    always_comb begin : operand_mux
        logic [REG_ADDR_W-1:0] sa;
        logic                  found;
        logic                  sb_hit;
        sa         = '0;
        found      = 1'b0;
        sb_hit     = 1'b0;
        o_src_data = i_src_rf_data;
        src_hz     = '0;
        for (int n = 0; n < NUM_SRC; n++) begin
            sa     = i_src_addr[n*REG_ADDR_W +: REG_ADDR_W];
            found  = 1'b0;
            sb_hit = 1'b0;
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                if (sb_valid[i] && (sb_addr[i] == sa)) sb_hit = 1'b1;
            end
            if (i_src_valid[n] && (sa != '0)) begin
                // Youngest matching pipeline source wins.
                for (int k = 0; k < NUM_FWD; k++) begin
                    if (!found && i_fwd_valid[k]
                        && (i_fwd_addr[k*REG_ADDR_W +: REG_ADDR_W] == sa)) begin
                        found = 1'b1;
                        if (i_fwd_ready[k])
                            o_src_data[n*DATA_WIDTH +: DATA_WIDTH] =
                                i_fwd_data[k*DATA_WIDTH +: DATA_WIDTH];
                        else
                            src_hz[n] = 1'b1;
                    end
                end
                if (!found) begin
                    if (i_done_valid && (i_done_addr == sa))
                        o_src_data[n*DATA_WIDTH +: DATA_WIDTH] = i_done_data;
                    else if (sb_hit)
                        src_hz[n] = 1'b1;
                end
            end
        end
    end

    assign o_hazard = |src_hz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_valid <= '0;
            for (int i = 0; i < MAX_INFLIGHT; i++) sb_addr[i] <= '0;
        end else begin
            sb_valid <= i_flush ? '0 : sb_valid_n;
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                if (do_issue && alloc_oh[i]) sb_addr[i] <= i_issue_addr;
            end
        end
    end

`ifdef FWD_SCOREBOARD_PERF_EN
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_q <= '0;
        else if (o_hazard && (stall_q != '1))
            stall_q <= stall_q + CNT_W'(1);
    end

    assign o_stall_cycles = stall_q;
`else
    assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Directed self-checking bench for fwd_scoreboard_unit (default parameters).
module tb_fwd_scoreboard_unit;

`ifdef FWD_SCOREBOARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  src_valid;
    logic [9:0]  src_addr;
    logic [63:0] src_rf;
    logic [2:0]  fwd_valid;
    logic [14:0] fwd_addr;
    logic [95:0] fwd_data;
    logic [2:0]  fwd_ready;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        issue_ready;
    logic        done_valid;
    logic [4:0]  done_addr;
    logic [31:0] done_data;
    logic        flush;
    logic [63:0] src_data;
    logic        hazard;
    logic [2:0]  pending;
    logic [15:0] stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fwd_scoreboard_unit dut (
        .clk             (clk),
        .rst             (rst),
        .i_src_valid     (src_valid),
        .i_src_addr      (src_addr),
        .i_src_rf_data   (src_rf),
        .i_fwd_valid     (fwd_valid),
        .i_fwd_addr      (fwd_addr),
        .i_fwd_data      (fwd_data),
        .i_fwd_ready     (fwd_ready),
        .i_issue_valid   (issue_valid),
        .i_issue_addr    (issue_addr),
        .o_issue_ready   (issue_ready),
        .i_done_valid    (done_valid),
        .i_done_addr     (done_addr),
        .i_done_data     (done_data),
        .i_flush         (flush),
        .o_src_data      (src_data),
        .o_hazard        (hazard),
        .o_pending_count (pending),
        .o_stall_cycles  (stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int n, input logic v, input logic [4:0] a);
        src_valid[n]       = v;
        src_addr[n*5 +: 5] = a;
    endtask

    task automatic set_fwd(input int k, input logic v, input logic [4:0] a,
                           input logic r, input logic [31:0] d);
        fwd_valid[k]        = v;
        fwd_addr[k*5 +: 5]  = a;
        fwd_ready[k]        = r;
        fwd_data[k*32 +: 32] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        src_valid   = '0;
        src_addr    = '0;
        src_rf      = {32'h2222_0000, 32'h1111_0000};
        fwd_valid   = '0;
        fwd_addr    = '0;
        fwd_data    = '0;
        fwd_ready   = '0;
        issue_valid = 1'b0;
        issue_addr  = 5'd5;
        done_valid  = 1'b0;
        done_addr   = '0;
        done_data   = '0;
        flush       = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;

        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_ready", 64'(issue_ready), 64'd1);
        chk("rst_hazard", 64'(hazard), 64'd0);
        chk("rst_data", src_data, {32'h2222_0000, 32'h1111_0000});

        // forwarding priority
        set_src(0, 1'b1, 5'd5);
        set_fwd(0, 1'b1, 5'd5, 1'b1, 32'hAAAA);
        set_fwd(2, 1'b1, 5'd5, 1'b1, 32'hCCCC);
        #1;
        chk("prio_fwd0", src_data, {32'h2222_0000, 32'h0000_AAAA});
        chk("prio_hazard", 64'(hazard), 64'd0);
        set_fwd(0, 1'b0, 5'd5, 1'b1, 32'hAAAA);
        #1;
        chk("prio_fwd2", src_data, {32'h2222_0000, 32'h0000_CCCC});
        set_src(0, 1'b0, 5'd0);
        set_fwd(2, 1'b0, 5'd0, 1'b0, 32'h0);
        tick();

        // load-use stall
        set_fwd(0, 1'b1, 5'd7, 1'b0, 32'hBEEF);
        set_src(1, 1'b1, 5'd7);
        #1;
        chk("lu_hazard", 64'(hazard), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        set_src(1, 1'b1, 5'd0);
        set_fwd(0, 1'b1, 5'd0, 1'b1, 32'hDEAD);
        #1;
        chk("lu_r0_hazard", 64'(hazard), 64'd0);
        chk("lu_r0_data", src_data, {32'h2222_0000, 32'h1111_0000});
        chk("lu_stall3", 64'(stall), PERF ? 64'd3 : 64'd0);
        set_src(1, 1'b0, 5'd0);
        set_fwd(0, 1'b0, 5'd0, 1'b0, 32'h0);
        tick();

        // scoreboard with done bypass
        issue_valid = 1'b1;
        issue_addr  = 5'd9;
        #1;
        chk("sb_issue_ready", 64'(issue_ready), 64'd1);
        tick();
        issue_valid = 1'b0;
        set_src(0, 1'b1, 5'd9);
        #1;
        chk("sb_hazard", 64'(hazard), 64'd1);
        chk("sb_pending1", 64'(pending), 64'd1);
        done_valid = 1'b1;
        done_addr  = 5'd9;
        done_data  = 32'h1234;
        #1;
        chk("sb_bypass", src_data, {32'h2222_0000, 32'h0000_1234});
        chk("sb_bypass_hz", 64'(hazard), 64'd0);
        tick();
        done_valid = 1'b0;
        #1;
        chk("sb_pending0", 64'(pending), 64'd0);
        chk("sb_clear_hz", 64'(hazard), 64'd0);
        set_src(0, 1'b0, 5'd0);

        // fill, WAW and full
        for (int a = 1; a <= 4; a++) begin
            issue_valid = 1'b1;
            issue_addr  = 5'(a);
            tick();
            if (a == 2) begin
                issue_valid = 1'b0;
                issue_addr  = 5'd2;
                #1;
                chk("waw_block", 64'(issue_ready), 64'd0);
                issue_addr = 5'd3;
                #1;
                chk("waw_other", 64'(issue_ready), 64'd1);
            end
        end
        issue_valid = 1'b0;
        issue_addr  = 5'd6;
        #1;
        chk("full_pending4", 64'(pending), 64'd4);
        chk("full_ready6", 64'(issue_ready), 64'd0);
        issue_addr = 5'd2;
        #1;
        chk("full_ready2", 64'(issue_ready), 64'd0);
        issue_addr = 5'd0;
        #1;
        chk("full_ready_r0", 64'(issue_ready), 64'd1);
        done_valid  = 1'b1;
        done_addr   = 5'd3;
        issue_valid = 1'b1;
        issue_addr  = 5'd6;
        #1;
        chk("done_issue_ready", 64'(issue_ready), 64'd1);
        tick();
        done_valid  = 1'b0;
        issue_valid = 1'b0;
        #1;
        chk("done_issue_cnt", 64'(pending), 64'd4);
        done_valid  = 1'b1;
        done_addr   = 5'd6;
        issue_valid = 1'b1;
        issue_addr  = 5'd6;
        #1;
        chk("same_addr_ready", 64'(issue_ready), 64'd1);
        tick();
        done_valid  = 1'b0;
        issue_valid = 1'b0;
        set_src(0, 1'b1, 5'd6);
        #1;
        chk("same_addr_cnt", 64'(pending), 64'd4);
        chk("same_addr_hz", 64'(hazard), 64'd1);
        set_src(0, 1'b0, 5'd0);
        done_valid = 1'b1;
        done_addr  = 5'd20;
        tick();
        #1;
        chk("done_nomatch", 64'(pending), 64'd4);
        done_addr = 5'd4;
        tick();
        done_valid = 1'b0;
        #1;
        chk("done_r4", 64'(pending), 64'd3);

        // flush
        flush       = 1'b1;
        issue_valid = 1'b1;
        issue_addr  = 5'd8;
        done_valid  = 1'b1;
        done_addr   = 5'd1;
        #1;
        chk("flush_ready", 64'(issue_ready), 64'd0);
        tick();
        flush       = 1'b0;
        issue_valid = 1'b0;
        done_valid  = 1'b0;
        set_src(0, 1'b1, 5'd8);
        #1;
        chk("flush_pending", 64'(pending), 64'd0);
        chk("flush_r8_hz", 64'(hazard), 64'd0);
        chk("flush_stall", 64'(stall), PERF ? 64'd3 : 64'd0);
        set_src(0, 1'b0, 5'd0);

        // async reset mid-operation
        issue_valid = 1'b1;
        issue_addr  = 5'd10;
        tick();
        issue_addr = 5'd11;
        tick();
        issue_valid = 1'b0;
        set_fwd(0, 1'b1, 5'd7, 1'b0, 32'h0);
        set_src(1, 1'b1, 5'd7);
        repeat (7) @(posedge clk);
        #1;
        set_fwd(0, 1'b0, 5'd0, 1'b0, 32'h0);
        set_src(1, 1'b0, 5'd0);
        issue_addr = 5'd10;
        #1;
        chk("pre_rst_pending", 64'(pending), 64'd2);
        chk("pre_rst_stall", 64'(stall), PERF ? 64'd10 : 64'd0);
        chk("pre_rst_ready", 64'(issue_ready), 64'd0);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_pending", 64'(pending), 64'd0);
        chk("async_rst_stall", 64'(stall), 64'd0);
        chk("async_rst_ready", 64'(issue_ready), 64'd1);
        tick();
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
